// File: rtl/coco_sd_pkg.sv
// Shared types and constants for the SD sector client.
package coco_sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } sd_state_e;

    localparam int SECTOR_BYTES = 512;
    localparam int LBA_W        = 32;
    localparam int BUF_AW       = $clog2(SECTOR_BYTES);
    localparam int TMO_W        = 24;

    // Whole sectors in an image; a trailing partial sector is not addressable.
    function automatic logic [LBA_W-1:0] sector_count(input logic [63:0] size_bytes);
        return size_bytes[40:9];
    endfunction

endpackage

// File: rtl/sd_sector_buf.sv
// 512x8 true dual-port sector buffer, registered read on both ports.
// SD port wins a same-address same-cycle write; reads return pre-write data.
module sd_sector_buf
    import coco_sd_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [BUF_AW-1:0] ctl_addr,
    input  logic [7:0]        ctl_din,
    input  logic              ctl_we,
    output logic [7:0]        ctl_dout,
    input  logic [BUF_AW-1:0] sd_addr,
    input  logic [7:0]        sd_din,
    input  logic              sd_we,
    output logic [7:0]        sd_dout
);

    logic [7:0] mem [SECTOR_BYTES];
    logic [7:0] ctl_dout_q;
    logic [7:0] sd_dout_q;

    // SD write is issued last so it overrides the controller on an address collision.
    always_ff @(posedge clk_sys) begin
        if (ctl_we) begin
            mem[ctl_addr] <= ctl_din;
        end
        if (sd_we) begin
            mem[sd_addr] <= sd_din;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ctl_dout_q <= 8'h00;
            sd_dout_q  <= 8'h00;
        end else begin
            ctl_dout_q <= mem[ctl_addr];
            sd_dout_q  <= mem[sd_addr];
        end
    end

    assign ctl_dout = ctl_dout_q;
    assign sd_dout  = sd_dout_q;

endmodule

// File: rtl/sd_sector_client.sv
// Turns one-sector read/write commands into user_io sd_rd/sd_wr/sd_ack handshakes,
// tracks mounted image sizes and owns the sector buffer shared with user_io.
module sd_sector_client
    import coco_sd_pkg::*;
#(
    parameter int               DRIVES      = 4,
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_drive,
    input  logic [LBA_W-1:0]  req_lba,
    output logic              done,
    output logic              err,
    input  logic [BUF_AW-1:0] buf_addr,
    input  logic [7:0]        buf_din,
    input  logic              buf_we,
    output logic [7:0]        buf_dout,
    output logic [DRIVES-1:0] mounted,
    input  logic [DRIVES-1:0] img_mounted,
    input  logic [63:0]       img_size,
    output logic [LBA_W-1:0]  sd_lba,
    output logic [DRIVES-1:0] sd_rd,
    output logic [DRIVES-1:0] sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din
);

    sd_state_e          state_q, state_d;
    logic [1:0]         drive_q, drive_d;
    logic               write_q, write_d;
    logic [LBA_W-1:0]   sd_lba_q, sd_lba_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               ready_en_q, ready_en_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [LBA_W-1:0]   sectors_q [DRIVES];
    logic [LBA_W-1:0]   sectors_d [DRIVES];
    logic [DRIVES-1:0]  drive_onehot;
    logic               accept;
    logic               reject;

    // Mount table: every flagged slot takes the size presented this cycle.
    always_comb begin
        for (int i = 0; i < DRIVES; i++) begin
            sectors_d[i] = img_mounted[i] ? sector_count(img_size) : sectors_q[i];
            mounted[i]   = |sectors_q[i];
        end
    end

    // Holding off while sd_ack is high keeps us from racing a host transfer
    // that was already in flight when reset was released.
    assign req_ready = ready_en_q && (state_q == IDLE) && !sd_ack;
    assign accept    = req_valid && req_ready;
    assign reject    = !mounted[req_drive] || (req_lba >= sectors_q[req_drive]);

    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        write_d    = write_q;
        sd_lba_d   = sd_lba_q;
        err_d      = err_q;
        tmo_d      = '0;
        done_d     = (state_q == DONE);
        ack_d      = sd_ack;
        ready_en_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    drive_d = req_drive;
                    write_d = req_write;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sd_lba_d = req_lba;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (sd_ack) begin
                    state_d = XFER;
                end else if (tmo_q == TIMEOUT_CYC - 1'b1) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            XFER: begin
                if (ack_q && !sd_ack) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            drive_q    <= 2'd0;
            write_q    <= 1'b0;
            sd_lba_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            ready_en_q <= 1'b0;
            tmo_q      <= '0;
            for (int i = 0; i < DRIVES; i++) begin
                sectors_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            drive_q    <= drive_d;
            write_q    <= write_d;
            sd_lba_q   <= sd_lba_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            ready_en_q <= ready_en_d;
            tmo_q      <= tmo_d;
            for (int i = 0; i < DRIVES; i++) begin
                sectors_q[i] <= sectors_d[i];
            end
        end
    end

    // Request bits decode straight from state, so leaving REQ (ack, timeout
    // or async reset) drops them with no extra cycle.
    assign drive_onehot = DRIVES'(1) << drive_q;
    assign sd_rd  = (state_q == REQ && !write_q) ? drive_onehot : '0;
    assign sd_wr  = (state_q == REQ &&  write_q) ? drive_onehot : '0;
    assign sd_lba = sd_lba_q;
    assign done   = done_q;
    assign err    = err_q;

    sd_sector_buf u_buf (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ctl_addr (buf_addr),
        .ctl_din  (buf_din),
        .ctl_we   (buf_we),
        .ctl_dout (buf_dout),
        .sd_addr  (sd_buff_addr),
        .sd_din   (sd_buff_dout),
        .sd_we    (sd_buff_wr),
        .sd_dout  (sd_buff_din)
    );

endmodule

// File: tb/tb_sd_sector_client.sv
// Directed bench for sd_sector_client with a small user_io host model.
module tb_sd_sector_client;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_drive;
    logic [31:0] req_lba;
    logic        done;
    logic        err;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;
    logic [3:0]  mounted;
    logic [3:0]  img_mounted;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic [3:0]  sd_rd;
    logic [3:0]  sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    sd_sector_client #(.DRIVES(4), .TIMEOUT_CYC(24'd100)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_drive    (req_drive),
        .req_lba      (req_lba),
        .done         (done),
        .err          (err),
        .buf_addr     (buf_addr),
        .buf_din      (buf_din),
        .buf_we       (buf_we),
        .buf_dout     (buf_dout),
        .mounted      (mounted),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    typedef struct {
        logic        w;
        logic [1:0]  d;
        logic [31:0] lba;
        logic        rej;
        logic [7:0]  pat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mount(input logic [3:0] mask, input logic [63:0] size);
        @(negedge clk_sys);
        img_size    = size;
        img_mounted = mask;
        @(negedge clk_sys);
        img_mounted = 4'b0000;
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic issue(input logic w, input logic [1:0] d, input logic [31:0] lba);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (!req_ready) begin
            check("ready_wait", 64'd0, 64'd1);
        end
        req_write = w;
        req_drive = d;
        req_lba   = lba;
        req_valid = 1'b1;
        @(negedge clk_sys);
        req_valid = 1'b0;
    endtask

    task automatic fill_buffer();
        for (int i = 0; i < 512; i++) begin
            buf_addr = 9'(i);
            buf_din  = 8'(i);
            buf_we   = 1'b1;
            @(negedge clk_sys);
        end
        buf_we = 1'b0;
    endtask

    task automatic readback(input logic [7:0] pat);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            buf_addr = 9'(i);
            @(negedge clk_sys);
            if (buf_dout !== (8'(i) ^ pat)) bad++;
        end
        check("buf_readback_bad", 64'(bad), 64'd0);
    endtask

    // Host side of an accepted command: ack, move 512 bytes, release.
    task automatic serve_ok(input logic w, input logic [1:0] d, input logic [31:0] lba,
                            input logic [7:0] pat);
        int n;
        int bad;
        int pulses;
        logic [3:0] mask;
        logic err_at_done;
        mask = 4'b0001 << d;
        n = 0;
        while ((sd_rd | sd_wr) == 4'b0000 && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        check("sd_rd", 64'(sd_rd), w ? 64'd0 : 64'(mask));
        check("sd_wr", 64'(sd_wr), w ? 64'(mask) : 64'd0);
        check("sd_lba", 64'(sd_lba), 64'(lba));
        check("busy_not_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        check("req_drop_on_ack", 64'(sd_rd | sd_wr), 64'd0);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            if (!w) begin
                sd_buff_dout = 8'(i) ^ pat;
                sd_buff_wr   = 1'b1;
            end
            @(negedge clk_sys);
            if (w && sd_buff_din !== 8'(i)) bad++;
        end
        sd_buff_wr = 1'b0;
        if (w) check("sd_buff_din_bad", 64'(bad), 64'd0);
        sd_ack = 1'b0;
        pulses = 0;
        err_at_done = 1'bx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_sys);
            if (done) begin
                pulses++;
                err_at_done = err;
            end
        end
        check("done_pulses", 64'(pulses), 64'd1);
        check("err_ok", 64'(err_at_done), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0] = '{w: 1'b0, d: 2'd1, lba: 32'd5,          rej: 1'b0, pat: 8'h5A};
        vecs[1] = '{w: 1'b0, d: 2'd1, lba: 32'd360,        rej: 1'b1, pat: 8'h00};
        vecs[2] = '{w: 1'b0, d: 2'd2, lba: 32'd0,          rej: 1'b1, pat: 8'h00};
        vecs[3] = '{w: 1'b1, d: 2'd1, lba: 32'd359,        rej: 1'b0, pat: 8'h00};
        vecs[4] = '{w: 1'b0, d: 2'd0, lba: 32'd0,          rej: 1'b0, pat: 8'h3C};
        vecs[5] = '{w: 1'b0, d: 2'd0, lba: 32'd1,          rej: 1'b1, pat: 8'h00};
        vecs[6] = '{w: 1'b1, d: 2'd3, lba: 32'd0,          rej: 1'b1, pat: 8'h00};
        vecs[7] = '{w: 1'b0, d: 2'd1, lba: 32'hFFFF_FFFF, rej: 1'b1, pat: 8'h00};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_drive    = 2'd0;
        req_lba      = 32'd0;
        buf_addr     = 9'd0;
        buf_din      = 8'd0;
        buf_we       = 1'b0;
        img_mounted  = 4'b0000;
        img_size     = 64'd0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'd0;
        sd_buff_dout = 8'd0;
        sd_buff_wr   = 1'b0;

        repeat (3) @(negedge clk_sys);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
        check("rst_sd_lba", 64'(sd_lba), 64'd0);
        check("rst_mounted", 64'(mounted), 64'd0);
        reset = 1'b0;
        #1;
        check("ready_before_first_edge", 64'(req_ready), 64'd0);
        @(negedge clk_sys);
        check("ready_after_first_edge", 64'(req_ready), 64'd1);

        // 184320 B -> 360 sectors; 1000 B -> 1 sector; 511 B -> 0 sectors (unmounted).
        mount(4'b0010, 64'd184320);
        mount(4'b0001, 64'd1000);
        mount(4'b1000, 64'd511);
        check("mounted_mask", 64'(mounted), 64'h3);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].w && !vecs[v].rej) fill_buffer();
            issue(vecs[v].w, vecs[v].d, vecs[v].lba);
            if (vecs[v].rej) begin
                check("rej_done_early", 64'(done), 64'd0);
                check("rej_no_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
                @(negedge clk_sys);
                check("rej_done_at_2", 64'(done), 64'd1);
                check("rej_err", 64'(err), 64'd1);
                check("rej_no_sd_req2", 64'({sd_rd, sd_wr}), 64'd0);
            end else begin
                serve_ok(vecs[v].w, vecs[v].d, vecs[v].lba, vecs[v].pat);
                if (!vecs[v].w) readback(vecs[v].pat);
            end
        end

        // Host never acks: request must stay up for exactly 100 cycles.
        issue(1'b0, 2'd1, 32'd0);
        n = 0;
        while (sd_rd != 4'b0000 && n < 300) begin
            n++;
            @(negedge clk_sys);
        end
        check("timeout_req_cycles", 64'(n), 64'd100);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) begin
                pulses++;
                check("timeout_err", 64'(err), 64'd1);
            end
            @(negedge clk_sys);
        end
        check("timeout_done_pulses", 64'(pulses), 64'd1);
        check("timeout_ready_back", 64'(req_ready), 64'd1);

        // Same-cycle write collision at the last address: SD data wins.
        sd_buff_addr = 9'h1FF;
        sd_buff_dout = 8'hAA;
        sd_buff_wr   = 1'b1;
        buf_addr     = 9'h1FF;
        buf_din      = 8'h55;
        buf_we       = 1'b1;
        @(negedge clk_sys);
        sd_buff_wr = 1'b0;
        buf_we     = 1'b0;
        @(negedge clk_sys);
        check("collision_sd_wins", 64'(buf_dout), 64'hAA);

        // Reset in XFER with ack held across release.
        issue(1'b0, 2'd1, 32'd7);
        n = 0;
        while (sd_rd == 4'b0000 && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("arst_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
        check("arst_sd_lba", 64'(sd_lba), 64'd0);
        check("arst_mounted", 64'(mounted), 64'd0);
        check("arst_done_err", 64'({done, err}), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        @(negedge clk_sys);
        reset        = 1'b0;
        sd_buff_addr = 9'd3;
        sd_buff_dout = 8'hC3;
        sd_buff_wr   = 1'b1;
        @(negedge clk_sys);
        sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("ack_hold_not_ready", 64'(req_ready), 64'd0);
        check("ack_hold_no_req", 64'({sd_rd, sd_wr}), 64'd0);
        sd_ack = 1'b0;
        #1;
        check("ready_after_ack_low", 64'(req_ready), 64'd1);
        buf_addr = 9'd3;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("strobe_during_hold", 64'(buf_dout), 64'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
